fetch_stage: RTL and testbench

FETCH_STAGE -- requirements
Module: fetch_stage

---
 rtl/fetch_stage.sv | 155 +++++++++++++++
 tb/tb_fetch_stage.sv | 283 ++++++++++++++++++++++++++++
 2 files changed

// File: rtl/fetch_stage.sv
`default_nettype none
// ============================================================================
// Module      : fetch_stage
// Description : Instruction fetch stage with a single-outstanding request
//               memory interface, redirect kill handling, a one-entry skid
//               buffer and the IF/ID pipeline register.
// Revision    : 1.0 - initial release
// ============================================================================

module fetch_stage #(
    parameter logic [31:0] RESET_PC = 32'h0000_0000
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        PCSrc,
    input  logic [31:0] PCTarget,
    input  logic        StallD,
    input  logic        FlushD,
    output logic        imem_req,
    output logic [31:0] imem_addr,
    input  logic        imem_gnt,
    input  logic        imem_rvalid,
    input  logic [31:0] imem_rdata,
    output logic [31:0] InstrD,
    output logic [31:0] PCD,
    output logic [31:0] PCPlus4D,
    output logic        ValidD
);

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        FETCH = 2'd1,
        WAIT  = 2'd2,
        HOLD  = 2'd3
    } state_t;

    state_t      state;
    state_t      state_next;
    logic [31:0] pcf;
    logic [31:0] pcf_next;
    logic [31:0] pcf_plus4;
    logic [31:0] redirect_pc;
    logic        kill;
    logic        kill_next;
    logic [31:0] skid_instr;
    logic [31:0] skid_next;
    logic        deliver;
    logic [31:0] deliver_instr;

    assign pcf_plus4   = pcf + 32'd4;
    assign redirect_pc = {PCTarget[31:2], 2'b00};
    assign imem_addr   = pcf;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state      <= IDLE;
            pcf        <= RESET_PC;
            kill       <= 1'b0;
            skid_instr <= 32'd0;
        end else begin
            state      <= state_next;
            pcf        <= pcf_next;
            kill       <= kill_next;
            skid_instr <= skid_next;
        end
    end

    always_comb begin
        state_next    = state;
        pcf_next      = pcf;
        kill_next     = kill;
        skid_next     = skid_instr;
        deliver       = 1'b0;
        deliver_instr = imem_rdata;
        imem_req      = 1'b0;

        case (state)
            IDLE: begin
                state_next = FETCH;
            end
            FETCH: begin
                imem_req = 1'b1;
                if (imem_gnt) begin
                    state_next = WAIT;
                    // A redirect in the grant cycle orphans the request just accepted.
                    kill_next  = PCSrc;
                end
            end
            WAIT: begin
                if (imem_rvalid) begin
                    if (kill || PCSrc) begin
                        kill_next  = 1'b0;
                        state_next = FETCH;
                    end else if (!StallD) begin
                        deliver    = 1'b1;
                        pcf_next   = pcf_plus4;
                        state_next = FETCH;
                    end else begin
                        skid_next  = imem_rdata;
                        state_next = HOLD;
                    end
                end else if (PCSrc) begin
                    kill_next = 1'b1;
                end
            end
            HOLD: begin
                if (PCSrc) begin
                    state_next = FETCH;
                end else if (!StallD) begin
                    deliver       = 1'b1;
                    deliver_instr = skid_instr;
                    pcf_next      = pcf_plus4;
                    state_next    = FETCH;
                end
            end
            default: begin
                state_next = IDLE;
            end
        endcase

        // Redirect wins over any sequential PC advance.
        if (PCSrc) begin
            pcf_next = redirect_pc;
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            InstrD   <= 32'd0;
            PCD      <= 32'd0;
            PCPlus4D <= 32'd0;
            ValidD   <= 1'b0;
        end else if (FlushD) begin
            InstrD   <= 32'd0;
            PCD      <= 32'd0;
            PCPlus4D <= 32'd0;
            ValidD   <= 1'b0;
        end else if (!StallD) begin
            if (deliver) begin
                InstrD   <= deliver_instr;
                PCD      <= pcf;
                PCPlus4D <= pcf_plus4;
                ValidD   <= 1'b1;
            end else begin
                InstrD   <= 32'd0;
                PCD      <= 32'd0;
                PCPlus4D <= 32'd0;
                ValidD   <= 1'b0;
            end
        end
    end

endmodule

`default_nettype wire

// File: tb/tb_fetch_stage.sv
`default_nettype none
// ============================================================================
// Module      : tb_fetch_stage
// Description : Directed self-checking bench for fetch_stage.
// Revision    : 1.0 - initial release
// ============================================================================

module tb_fetch_stage;

    logic        clk;
    logic        rst;
    logic        rst2;
    logic        PCSrc;
    logic [31:0] PCTarget;
    logic        StallD;
    logic        FlushD;
    logic        imem_gnt;
    logic        imem_rvalid;
    logic [31:0] imem_rdata;

    logic        imem_req;
    logic [31:0] imem_addr;
    logic [31:0] InstrD;
    logic [31:0] PCD;
    logic [31:0] PCPlus4D;
    logic        ValidD;

    logic        imem_req2;
    logic [31:0] imem_addr2;
    logic [31:0] InstrD2;
    logic [31:0] PCD2;
    logic [31:0] PCPlus4D2;
    logic        ValidD2;

    int n_checks;
    int n_fail;

    localparam logic [31:0] C_I1  = 32'h0050_0093;
    localparam logic [31:0] C_I2  = 32'h00A0_0113;
    localparam logic [31:0] C_I3  = 32'h0020_8193;
    localparam logic [31:0] C_I4  = 32'h0041_0233;
    localparam logic [31:0] C_I5  = 32'h0000_0013;
    localparam logic [31:0] C_I6  = 32'h1234_5678;
    localparam logic [31:0] C_BAD = 32'hDEAD_BEEF;

    fetch_stage u_dut (
        .clk         (clk),
        .rst         (rst),
        .PCSrc       (PCSrc),
        .PCTarget    (PCTarget),
        .StallD      (StallD),
        .FlushD      (FlushD),
        .imem_req    (imem_req),
        .imem_addr   (imem_addr),
        .imem_gnt    (imem_gnt),
        .imem_rvalid (imem_rvalid),
        .imem_rdata  (imem_rdata),
        .InstrD      (InstrD),
        .PCD         (PCD),
        .PCPlus4D    (PCPlus4D),
        .ValidD      (ValidD)
    );

    fetch_stage #(.RESET_PC(32'hFFFF_FFFC)) u_dut_wrap (
        .clk         (clk),
        .rst         (rst2),
        .PCSrc       (PCSrc),
        .PCTarget    (PCTarget),
        .StallD      (StallD),
        .FlushD      (FlushD),
        .imem_req    (imem_req2),
        .imem_addr   (imem_addr2),
        .imem_gnt    (imem_gnt),
        .imem_rvalid (imem_rvalid),
        .imem_rdata  (imem_rdata),
        .InstrD      (InstrD2),
        .PCD         (PCD2),
        .PCPlus4D    (PCPlus4D2),
        .ValidD      (ValidD2)
    );

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    task automatic check(input string tag, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h expected %h", tag, act, exp);
        end
    endtask

    // Advance one cycle; inputs and samples land 1 time unit after the edge.
    task automatic step();
        @(posedge clk);
        #1;
    endtask

    initial begin
        n_checks    = 0;
        n_fail      = 0;
        rst         = 1'b1;
        rst2        = 1'b1;
        PCSrc       = 1'b0;
        PCTarget    = 32'd0;
        StallD      = 1'b0;
        FlushD      = 1'b0;
        imem_gnt    = 1'b0;
        imem_rvalid = 1'b0;
        imem_rdata  = 32'd0;

        step();
        step();
        check("rst_req",    {31'd0, imem_req}, 32'd0);
        check("rst_addr",   imem_addr, 32'd0);
        check("rst_instr",  InstrD, 32'd0);
        check("rst_valid",  {31'd0, ValidD}, 32'd0);
        check("rst2_addr",  imem_addr2, 32'hFFFF_FFFC);

        // Streaming fetch with an always-granting, 1-cycle memory.
        rst = 1'b0;
        check("idle_req", {31'd0, imem_req}, 32'd0);
        step();
        check("fetch0_req",  {31'd0, imem_req}, 32'd1);
        check("fetch0_addr", imem_addr, 32'd0);
        imem_gnt = 1'b1;
        step();
        check("wait0_req", {31'd0, imem_req}, 32'd0);
        imem_rvalid = 1'b1;
        imem_rdata  = C_I1;
        step();
        imem_rvalid = 1'b0;
        check("i1_instr",  InstrD, C_I1);
        check("i1_pcd",    PCD, 32'd0);
        check("i1_pc4",    PCPlus4D, 32'd4);
        check("i1_valid",  {31'd0, ValidD}, 32'd1);
        check("i1_next",   imem_addr, 32'd4);
        check("i1_req",    {31'd0, imem_req}, 32'd1);
        step();
        check("bubble_valid", {31'd0, ValidD}, 32'd0);
        check("bubble_instr", InstrD, 32'd0);
        imem_rvalid = 1'b1;
        imem_rdata  = C_I2;
        step();
        imem_rvalid = 1'b0;
        check("i2_instr", InstrD, C_I2);
        check("i2_pcd",   PCD, 32'd4);
        check("i2_next",  imem_addr, 32'd8);

        // Stall across the response: skid buffer and HOLD.
        StallD = 1'b1;
        step();
        imem_rvalid = 1'b1;
        imem_rdata  = C_I3;
        step();
        imem_rvalid = 1'b0;
        check("hold_req",   {31'd0, imem_req}, 32'd0);
        check("hold_instr", InstrD, C_I2);
        check("hold_pcd",   PCD, 32'd4);
        check("hold_valid", {31'd0, ValidD}, 32'd1);
        step();
        check("hold2_req", {31'd0, imem_req}, 32'd0);
        step();
        check("hold3_req",   {31'd0, imem_req}, 32'd0);
        check("hold3_instr", InstrD, C_I2);
        StallD = 1'b0;
        step();
        check("i3_instr", InstrD, C_I3);
        check("i3_pcd",   PCD, 32'd8);
        check("i3_pc4",   PCPlus4D, 32'd12);
        check("i3_valid", {31'd0, ValidD}, 32'd1);
        check("i3_next",  imem_addr, 32'd12);
        check("i3_req",   {31'd0, imem_req}, 32'd1);

        // Redirect while waiting; stale response two cycles later is dropped.
        step();
        PCSrc    = 1'b1;
        PCTarget = 32'h0000_0103;
        step();
        PCSrc = 1'b0;
        check("kill_valid", {31'd0, ValidD}, 32'd0);
        check("kill_req",   {31'd0, imem_req}, 32'd0);
        step();
        imem_rvalid = 1'b1;
        imem_rdata  = C_BAD;
        step();
        imem_rvalid = 1'b0;
        check("redir_addr",  imem_addr, 32'h0000_0100);
        check("redir_req",   {31'd0, imem_req}, 32'd1);
        check("stale_valid", {31'd0, ValidD}, 32'd0);
        check("stale_instr", InstrD, 32'd0);
        step();
        check("redir_wait_valid", {31'd0, ValidD}, 32'd0);
        imem_rvalid = 1'b1;
        imem_rdata  = C_I4;
        step();
        imem_rvalid = 1'b0;
        check("i4_instr", InstrD, C_I4);
        check("i4_pcd",   PCD, 32'h0000_0100);
        check("i4_valid", {31'd0, ValidD}, 32'd1);
        check("i4_next",  imem_addr, 32'h0000_0104);

        // Flush overrides stall.
        imem_gnt = 1'b0;
        FlushD   = 1'b1;
        StallD   = 1'b1;
        step();
        FlushD = 1'b0;
        StallD = 1'b0;
        check("flush_instr", InstrD, 32'd0);
        check("flush_pcd",   PCD, 32'd0);
        check("flush_valid", {31'd0, ValidD}, 32'd0);

        // Redirect in FETCH without grant re-presents the new address.
        PCSrc    = 1'b1;
        PCTarget = 32'h0000_0202;
        step();
        PCSrc = 1'b0;
        check("fetch_redir_addr", imem_addr, 32'h0000_0200);
        check("fetch_redir_req",  {31'd0, imem_req}, 32'd1);
        imem_gnt = 1'b1;
        step();
        imem_rvalid = 1'b1;
        imem_rdata  = C_I5;
        step();
        imem_rvalid = 1'b0;
        check("i5_instr", InstrD, C_I5);
        check("i5_pcd",   PCD, 32'h0000_0200);

        // Asynchronous reset in the middle of WAIT.
        StallD = 1'b1;
        step();
        imem_gnt = 1'b0;
        #2;
        rst = 1'b1;
        #1;
        check("arst_instr", InstrD, 32'd0);
        check("arst_pcd",   PCD, 32'd0);
        check("arst_pc4",   PCPlus4D, 32'd0);
        check("arst_valid", {31'd0, ValidD}, 32'd0);
        check("arst_req",   {31'd0, imem_req}, 32'd0);
        check("arst_addr",  imem_addr, 32'd0);
        rst         = 1'b0;
        StallD      = 1'b0;
        imem_rvalid = 1'b1;
        imem_rdata  = C_BAD;
        check("arst_idle_req", {31'd0, imem_req}, 32'd0);
        step();
        check("arst_fetch_addr", imem_addr, 32'd0);
        check("arst_fetch_req",  {31'd0, imem_req}, 32'd1);
        step();
        check("arst_ignore_valid", {31'd0, ValidD}, 32'd0);
        check("arst_ignore_instr", InstrD, 32'd0);
        check("arst_still_fetch",  {31'd0, imem_req}, 32'd1);
        imem_rvalid = 1'b0;

        // PC wrap-around on the second instance.
        rst2 = 1'b0;
        step();
        check("wrap_addr", imem_addr2, 32'hFFFF_FFFC);
        check("wrap_req",  {31'd0, imem_req2}, 32'd1);
        imem_gnt = 1'b1;
        step();
        imem_gnt    = 1'b0;
        imem_rvalid = 1'b1;
        imem_rdata  = C_I6;
        step();
        imem_rvalid = 1'b0;
        check("wrap_instr", InstrD2, C_I6);
        check("wrap_pcd",   PCD2, 32'hFFFF_FFFC);
        check("wrap_pc4",   PCPlus4D2, 32'd0);
        check("wrap_valid", {31'd0, ValidD2}, 32'd1);
        check("wrap_next",  imem_addr2, 32'd0);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule

`default_nettype wire
